// File: rtl/drum_spi_pkg.sv
// Shared types and constants for the SPI packet reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, default packet length, counter-width helper.
package drum_spi_pkg;

    // Default number of bytes pulled from the slave per packet.
    localparam int PKT_BYTES_DEFAULT = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DONE = 3'd1,
        ST_SETUP     = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_ACK       = 3'd4,
        ST_GAP       = 3'd5
    } state_t;

    // Width of a counter that must hold 0..n-1; never narrower than 1 bit
    // so single-count configurations still elaborate.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level.
// Latency: 2 clk cycles from input change to q.
// Backpressure: none; free-running sampler.
//
// Ports:
//   clk  - sampling clock
//   rst  - synchronous active-high reset, clears both flops
//   d    - asynchronous input level
//   q    - synchronized output level
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mcu_packet_reader.sv
// SPI Mode-0 master that reads a fixed-length packet once the slave signals done.
// Latency: byte_valid on the clk edge that captures the 8th bit; pkt_valid on first ACK cycle.
// Backpressure: none; consumer must accept byte_valid/pkt_valid strobes when they fire.
//
// Ports:
//   clk, rst      - system clock, synchronous active-high reset
//   enable        - level arm; sampled only in IDLE, ignored once a read is underway
//   done_in       - asynchronous data-ready from the slave (synchronized internally)
//   sdo_in        - serial data from the slave, sampled on rising sck
//   sck, sdi      - SPI clock (idle low) and MOSI (tied low)
//   load          - packet acknowledge, high for ACK_CYC cycles after a packet
//   byte_data/idx - last assembled byte and its position in the packet
//   byte_valid    - one-cycle strobe per assembled byte
//   pkt_valid     - one-cycle strobe per completed packet
//   timeout_err   - one-cycle strobe when done never arrived
//   busy          - high in every state except IDLE
module mcu_packet_reader
    import drum_spi_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int PKT_BYTES   = PKT_BYTES_DEFAULT,
    parameter int SETUP_CYC   = 2,
    parameter int ACK_CYC     = 10,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       done_in,
    input  logic       sdo_in,
    output logic       sck,
    output logic       sdi,
    output logic       load,
    output logic [7:0] byte_data,
    output logic [4:0] byte_idx,
    output logic       byte_valid,
    output logic       pkt_valid,
    output logic       timeout_err,
    output logic       busy
);

    localparam int DIV_W  = cnt_width(CLK_DIV);
    localparam int BYTE_W = cnt_width(PKT_BYTES);
    localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int PH_W   = cnt_width((SETUP_CYC > ACK_CYC) ? SETUP_CYC : ACK_CYC);

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST  = BYTE_W'(PKT_BYTES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [PH_W-1:0]   SETUP_LAST = PH_W'(SETUP_CYC - 1);
    localparam logic [PH_W-1:0]   ACK_LAST   = PH_W'(ACK_CYC - 1);

    state_t            state;
    logic              done_s;
    logic [DIV_W-1:0]  div_cnt;
    logic [2:0]        bit_cnt;
    logic [BYTE_W-1:0] byte_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [PH_W-1:0]   ph_cnt;
    // Only 7 bits are stored: the 8th bit goes straight from sdo_in into byte_data.
    logic [6:0]        shreg;
    // Set once the final byte of the packet has been captured; the next
    // falling sck edge then ends the shift phase.
    logic              last_byte;

    // The slave never receives data from us.
    assign sdi = 1'b0;

    sync2 u_done_sync (
        .clk (clk),
        .rst (rst),
        .d   (done_in),
        .q   (done_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            tmo_cnt     <= '0;
            ph_cnt      <= '0;
            shreg       <= '0;
            last_byte   <= 1'b0;
            sck         <= 1'b0;
            load        <= 1'b0;
            byte_data   <= '0;
            byte_idx    <= '0;
            byte_valid  <= 1'b0;
            pkt_valid   <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            byte_valid  <= 1'b0;
            pkt_valid   <= 1'b0;
            timeout_err <= 1'b0;

            case (state)
                ST_IDLE: begin
                    sck  <= 1'b0;
                    load <= 1'b0;
                    if (enable) begin
                        state   <= ST_WAIT_DONE;
                        busy    <= 1'b1;
                        tmo_cnt <= '0;
                    end
                end

                ST_WAIT_DONE: begin
                    if (done_s) begin
                        state  <= ST_SETUP;
                        ph_cnt <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        // TIMEOUT_CYC full cycles spent here without done.
                        state       <= ST_IDLE;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                ST_SETUP: begin
                    if (ph_cnt == SETUP_LAST) begin
                        state     <= ST_SHIFT;
                        sck       <= 1'b0;
                        div_cnt   <= '0;
                        bit_cnt   <= '0;
                        byte_cnt  <= '0;
                        last_byte <= 1'b0;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end

                ST_SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!sck) begin
                            // Rising sck: the slave's bit has been stable for a
                            // full half-period, capture it MSB first.
                            sck     <= 1'b1;
                            shreg   <= {shreg[5:0], sdo_in};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7) begin
                                byte_data  <= {shreg, sdo_in};
                                byte_idx   <= 5'(byte_cnt);
                                byte_valid <= 1'b1;
                                // Hold the byte counter on the last byte so it
                                // never wraps within a packet.
                                if (byte_cnt == BYTE_LAST) begin
                                    last_byte <= 1'b1;
                                end else begin
                                    byte_cnt <= byte_cnt + 1'b1;
                                end
                            end
                        end else begin
                            // Falling sck: the slave shifts its next bit out here.
                            sck <= 1'b0;
                            if (last_byte) begin
                                state     <= ST_ACK;
                                load      <= 1'b1;
                                pkt_valid <= 1'b1;
                                ph_cnt    <= '0;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                ST_ACK: begin
                    if (ph_cnt == ACK_LAST) begin
                        state  <= ST_GAP;
                        load   <= 1'b0;
                        ph_cnt <= '0;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end

                ST_GAP: begin
                    if (ph_cnt == ACK_LAST) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    sck   <= 1'b0;
                    load  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcu_packet_reader.sv
// Directed bench for mcu_packet_reader: two instances (32-byte/div-4 and 1-byte/div-2)
// driven by a cycle-stepped slave model; results checked with immediate assertions.
module tb_mcu_packet_reader;

    localparam int TMO = 500;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance A: CLK_DIV=4, PKT_BYTES=32
    logic       enable, done_in, sdo_in;
    logic       sck, sdi, load, byte_valid, pkt_valid, timeout_err, busy;
    logic [7:0] byte_data;
    logic [4:0] byte_idx;

    // Instance B: CLK_DIV=2, PKT_BYTES=1
    logic       enable_b, done_b, sdo_b;
    logic       sck_b, sdi_b, load_b, byte_valid_b, pkt_valid_b, timeout_err_b, busy_b;
    logic [7:0] byte_data_b;
    logic [4:0] byte_idx_b;

    mcu_packet_reader #(
        .CLK_DIV(4), .PKT_BYTES(32), .SETUP_CYC(2), .ACK_CYC(10), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .done_in(done_in), .sdo_in(sdo_in),
        .sck(sck), .sdi(sdi), .load(load), .byte_data(byte_data), .byte_idx(byte_idx),
        .byte_valid(byte_valid), .pkt_valid(pkt_valid), .timeout_err(timeout_err), .busy(busy)
    );

    mcu_packet_reader #(
        .CLK_DIV(2), .PKT_BYTES(1), .SETUP_CYC(2), .ACK_CYC(10), .TIMEOUT_CYC(TMO)
    ) dut_b (
        .clk(clk), .rst(rst), .enable(enable_b), .done_in(done_b), .sdo_in(sdo_b),
        .sck(sck_b), .sdi(sdi_b), .load(load_b), .byte_data(byte_data_b), .byte_idx(byte_idx_b),
        .byte_valid(byte_valid_b), .pkt_valid(pkt_valid_b), .timeout_err(timeout_err_b), .busy(busy_b)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0] pat_a [32];
    logic [7:0] pat_b;

    int   bit_ptr, seen, pkt_cnt, load_cyc, tmo_cnt, rise_cnt, busy_cyc, t_tmo;
    logic prev_sck;
    int   bit_ptr_b, seen_b, pkt_b, load_cyc_b, rise_b, busy_cyc_b, t_r0, t_r1;
    logic prev_sck_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock, then act as the slaves and record DUT activity.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        // Slave A: release done once shifting starts; next bit on falling sck.
        if (sck && !prev_sck) begin
            rise_cnt++;
            done_in = 1'b0;
        end
        if (!sck && prev_sck) begin
            bit_ptr++;
            if (bit_ptr < 256) sdo_in = pat_a[5'(bit_ptr >> 3)][3'(7 - (bit_ptr & 7))];
        end
        prev_sck = sck;
        if (byte_valid) begin
            check("byte_data", 32'(byte_data), 32'(pat_a[5'(seen)]));
            check("byte_idx", 32'(byte_idx), seen);
            seen++;
        end
        if (pkt_valid)   pkt_cnt++;
        if (load)        load_cyc++;
        if (busy)        busy_cyc++;
        if (timeout_err) begin
            tmo_cnt++;
            t_tmo = cyc;
        end
        // Slave B
        if (sck_b && !prev_sck_b) begin
            if (rise_b == 0) t_r0 = cyc;
            if (rise_b == 1) t_r1 = cyc;
            rise_b++;
            done_b = 1'b0;
        end
        if (!sck_b && prev_sck_b) begin
            bit_ptr_b++;
            if (bit_ptr_b < 8) sdo_b = pat_b[3'(7 - bit_ptr_b)];
        end
        prev_sck_b = sck_b;
        if (byte_valid_b) begin
            check("b_byte_data", 32'(byte_data_b), 32'(pat_b));
            check("b_byte_idx", 32'(byte_idx_b), 0);
            seen_b++;
        end
        if (pkt_valid_b) pkt_b++;
        if (load_b)      load_cyc_b++;
        if (busy_b)      busy_cyc_b++;
    endtask

    task automatic clear_mon();
        bit_ptr = 0; seen = 0; pkt_cnt = 0; load_cyc = 0; tmo_cnt = 0;
        rise_cnt = 0; busy_cyc = 0; t_tmo = 0; prev_sck = sck;
        bit_ptr_b = 0; seen_b = 0; pkt_b = 0; load_cyc_b = 0; rise_b = 0;
        busy_cyc_b = 0; t_r0 = 0; t_r1 = 0; prev_sck_b = sck_b;
    endtask

    task automatic arm_a();
        clear_mon();
        sdo_in  = pat_a[0][7];
        done_in = 1'b1;
        enable  = 1'b1;
    endtask

    task automatic arm_b();
        clear_mon();
        sdo_b    = pat_b[7];
        done_b   = 1'b1;
        enable_b = 1'b1;
    endtask

    // Run until A is idle again; enable drops once drop_at bytes have arrived.
    task automatic wait_idle_a(input int budget, input int drop_at, input string tag);
        int n = 0;
        tick();
        n++;
        if (seen >= drop_at) enable = 1'b0;
        while (busy && n < budget) begin
            tick();
            n++;
            if (seen >= drop_at) enable = 1'b0;
        end
        check(tag, 32'(busy), 0);
    endtask

    task automatic wait_idle_b(input int budget, input string tag);
        int n = 0;
        tick();
        n++;
        enable_b = 1'b0;
        while (busy_b && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(busy_b), 0);
    endtask

    task automatic wait_seen(input int target, input int budget, input string tag);
        int n = 0;
        while (seen < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, seen, target);
    endtask

    int t_en;

    initial begin
        rst = 1'b1;
        enable = 1'b0; done_in = 1'b0; sdo_in = 1'b0;
        enable_b = 1'b0; done_b = 1'b0; sdo_b = 1'b0;
        pat_b = 8'h00;
        for (int k = 0; k < 32; k++) pat_a[5'(k)] = 8'(k);
        clear_mon();

        // Reset state
        repeat (3) tick();
        check("rst_outs_a", 32'({sck, sdi, load, byte_valid, pkt_valid, timeout_err, busy,
                                 byte_data, byte_idx}), 0);
        check("rst_outs_b", 32'({sck_b, sdi_b, load_b, byte_valid_b, pkt_valid_b, timeout_err_b,
                                 busy_b, byte_data_b, byte_idx_b}), 0);
        rst = 1'b0;
        tick();
        check("idle_after_rst", 32'(busy), 0);

        // Nominal 32-byte read, bytes 0x00..0x1F
        arm_a();
        wait_idle_a(3000, 0, "nom_idle");
        check("nom_bytes", seen, 32);
        check("nom_pkt", pkt_cnt, 1);
        check("nom_load_cyc", load_cyc, 10);
        check("nom_rises", rise_cnt, 256);
        check("nom_busy_cyc", busy_cyc, 2072);
        check("nom_sck_idle", 32'(sck), 0);

        // No done: timeout after TMO cycles in WAIT_DONE
        clear_mon();
        done_in = 1'b0;
        enable  = 1'b1;
        tick();
        t_en   = cyc;
        enable = 1'b0;
        for (int n = 0; n < TMO + 50 && tmo_cnt == 0; n++) tick();
        repeat (5) tick();
        check("tmo_count", tmo_cnt, 1);
        check("tmo_delay", t_tmo - t_en, TMO);
        check("tmo_busy_cyc", busy_cyc, TMO);
        check("tmo_busy_low", 32'(busy), 0);
        check("tmo_no_pkt", pkt_cnt, 0);

        // Reset mid-packet after byte 5, then re-arm
        arm_a();
        tick();
        enable = 1'b0;
        wait_seen(6, 2000, "rst_reach_b5");
        rst = 1'b1;
        tick();
        check("rst_mid_outs", 32'({sck, load, busy, byte_valid, pkt_valid}), 0);
        rst = 1'b0;
        repeat (20) tick();
        check("rst_mid_no_pkt", pkt_cnt, 0);
        check("rst_mid_no_byte", seen, 6);
        check("rst_mid_idle", 32'(busy), 0);
        arm_a();
        wait_idle_a(3000, 0, "rearm_idle");
        check("rearm_bytes", seen, 32);
        check("rearm_pkt", pkt_cnt, 1);
        check("rearm_busy_cyc", busy_cyc, 2072);

        // Enable dropped at byte 10, different data pattern
        for (int k = 0; k < 32; k++) pat_a[5'(k)] = 8'hC3 ^ 8'(k * 37);
        arm_a();
        wait_idle_a(3000, 10, "endrop_idle");
        check("endrop_bytes", seen, 32);
        check("endrop_pkt", pkt_cnt, 1);
        repeat (30) tick();
        check("endrop_stays_idle", 32'(busy), 0);
        check("endrop_busy_cyc", busy_cyc, 2072);

        // Bit order and CLK_DIV=2 on the single-byte instance
        pat_b = 8'hA5;
        arm_b();
        wait_idle_b(200, "b_a5_idle");
        check("b_a5_bytes", seen_b, 1);
        check("b_a5_pkt", pkt_b, 1);
        check("b_a5_rises", rise_b, 8);
        check("b_a5_period", t_r1 - t_r0, 4);
        check("b_a5_load_cyc", load_cyc_b, 10);
        check("b_a5_busy_cyc", busy_cyc_b, 56);

        pat_b = 8'h3C;
        arm_b();
        wait_idle_b(200, "b_3c_idle");
        check("b_3c_bytes", seen_b, 1);
        check("b_3c_rises", rise_b, 8);
        check("b_3c_pkt", pkt_b, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mcu_packet_reader.md
MCU_PACKET_READER -- requirements
Module: mcu_packet_reader

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per sck half-period; legal range >=2.
REQ-002 Parameter PKT_BYTES, default 32: bytes read per packet.
REQ-003 Parameter SETUP_CYC, default 2: clk cycles between done detect and first sck edge.
REQ-004 Parameter ACK_CYC, default 10: clk cycles load is held high, and then low, after a packet.
REQ-005 Parameter TIMEOUT_CYC, default 100000: maximum clk cycles spent waiting for done.
REQ-006 Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  arms packet reads; level-sensitive.
- done_in  in  1  data-ready from the SPI slave; asynchronous.
- sdo_in  in  1  serial data from the slave.
- sck  out  1  SPI clock; Mode 0, idle low.
- sdi  out  1  serial data to the slave; constant 0.
- load  out  1  packet acknowledge to the slave.
- byte_data  out  8  last assembled byte.
- byte_idx  out  5  index of byte_data, 0..PKT_BYTES-1.
- byte_valid  out  1  one-cycle strobe; byte_data and byte_idx valid.
- pkt_valid  out  1  one-cycle strobe; full packet received.
- timeout_err  out  1  one-cycle strobe; done wait expired.
- busy  out  1  high in every state except IDLE.

Function
REQ-007 done_in SHALL pass through a 2-flop synchronizer before use; done_s denotes its output.
REQ-008 FSM states SHALL be IDLE, WAIT_DONE, SETUP, SHIFT, ACK and GAP.
REQ-009 IDLE SHALL go to WAIT_DONE on the cycle after enable=1 is sampled.
REQ-010 WAIT_DONE SHALL go to SETUP when done_s=1 is sampled.
REQ-011 In WAIT_DONE, a timeout SHALL occur when TIMEOUT_CYC cycles elapse without done_s: pulse timeout_err for 1 cycle and go to IDLE.
REQ-012 SETUP SHALL last exactly SETUP_CYC cycles, with sck=0, then go to SHIFT.
REQ-013 In SHIFT, sck SHALL toggle every CLK_DIV clk cycles, starting low, for 8*PKT_BYTES full periods.
REQ-014 Sampling SHALL occur on the clk edge where registered sck goes 0->1, capturing sdo_in into the shift register MSB first.
REQ-015 On completing the 8th bit of a byte, byte_data SHALL update, byte_valid SHALL pulse 1 cycle later at most, and byte_idx SHALL equal the byte's position.
REQ-016 After the final falling sck edge, sck SHALL stay 0 and the FSM SHALL go to ACK.
REQ-017 ACK SHALL hold load=1 for ACK_CYC cycles; pkt_valid SHALL pulse on the first ACK cycle.
REQ-018 GAP SHALL hold load=0 for ACK_CYC cycles, then go to IDLE.
REQ-019 enable deasserting mid-packet SHALL NOT abort the read; the packet SHALL complete through GAP.
REQ-020 done_s falling during SHIFT SHALL be ignored.
REQ-021 The bit counter SHALL be 3 bits, wrapping 7->0. The byte counter SHALL be wide enough for PKT_BYTES-1 and SHALL NOT wrap within a packet.
REQ-022 The timeout counter SHALL be sized by $clog2(TIMEOUT_CYC+1) and SHALL clear on every entry to WAIT_DONE.

Reset
REQ-023 When rst=1 at a clk edge, all outputs SHALL be 0 on the next cycle, the FSM SHALL be in IDLE, and all counters and the synchronizer SHALL be 0.
REQ-024 rst asserted mid-packet SHALL discard the partial byte and packet, and SHALL produce no byte_valid or pkt_valid strobe.

Structure
REQ-025 Package drum_spi_pkg SHALL hold the FSM state enum and the shared constant PKT_BYTES_DEFAULT=32.
REQ-026 The done synchronizer SHALL be sub-module sync2 (1-bit, 2 flops, synchronous active-high reset). All other logic SHALL be in one module.

Verification
REQ-027 Bench scenarios:
- Nominal read: slave model shifts bytes 0x00..0x1F, changing data on falling sck. Required: 32 byte_valid strobes with byte_data equal to byte_idx, pkt_valid once, load high for 10 cycles.
- No done: enable=1, done_in held 0. Required: timeout_err pulses exactly once, 100000 cycles after WAIT_DONE entry; busy returns to 0.
- Bit order: single byte 0xA5 with PKT_BYTES=1. Required: byte_data=0xA5 and exactly 8 rising sck edges.
- Reset mid-packet: rst asserted after byte 5 for 1 cycle. Required: sck=0, load=0, busy=0 the next cycle, no pkt_valid, and a clean full packet on re-arm.
- Enable dropped at byte 10. Required: all 32 bytes delivered, pkt_valid asserted, then FSM stays in IDLE.
- Clock ratio: CLK_DIV=2. Required: sck period of 4 clk cycles and correct data capture.
